// File: rtl/key_repeat_ctrl_pkg.sv
// Shared definitions for the keyboard-to-move-request front end.
// HID keycodes, move-request bit positions (shared with block_logic),
// the per-action repeat state encoding and small helper functions.
package key_repeat_ctrl_pkg;

   // USB HID usage codes for the actions we recognise
   localparam logic [7:0] KEY_LEFT  = 8'h50;
   localparam logic [7:0] KEY_RIGHT = 8'h4F;
   localparam logic [7:0] KEY_DOWN  = 8'h51;
   localparam logic [7:0] KEY_ROT_L = 8'h1D;   // Z
   localparam logic [7:0] KEY_ROT_R = 8'h1B;   // X
   localparam logic [7:0] KEY_DROP  = 8'h2C;   // space

   // Bit positions inside move_req; identical to block_logic's can_move
   localparam int MV_LEFT  = 0;
   localparam int MV_RIGHT = 1;
   localparam int MV_DOWN  = 2;
   localparam int MV_ROT_L = 3;
   localparam int MV_ROT_R = 4;
   localparam int MV_WIDTH = 5;

   // Per-action repeat state. RS_DAS doubles as the "already reported"
   // state of edge-only channels, which never leave it while held.
   typedef enum logic [1:0] {
      RS_IDLE = 2'd0,
      RS_DAS  = 2'd1,
      RS_ARR  = 2'd2
   } repeat_state_t;

   // True when any of the four keycode slots carries the given code;
   // duplicates across slots naturally collapse to a single "held".
   function automatic logic key_held(input logic [31:0] kc,
                                     input logic [7:0]  code);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (kc[8*i +: 8] == code) hit = 1'b1;
      end
      return hit;
   endfunction

   // Frame counter width: enough for max(a,b)-1 with one spare bit
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      if (m < 1) m = 1;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/key_repeat_ctrl_channel.sv
// key_repeat_channel: one action's press / delayed-auto-shift / auto-repeat
// state machine. All state moves only on frame ticks; the pulse output is
// registered, so it is high exactly in the cycle after the tick.
//   DO_REPEAT=1, FIRST_DELAY>0 : IDLE -> DAS -> ARR (left/right)
//   DO_REPEAT=1, FIRST_DELAY=0 : IDLE -> ARR        (soft drop)
//   DO_REPEAT=0                : IDLE -> DAS, pulse on press only
module key_repeat_channel
   import key_repeat_ctrl_pkg::*;
#(
   parameter int FIRST_DELAY = 10,
   parameter int REPEAT      = 2,
   parameter bit DO_REPEAT   = 1'b1
) (
   input  logic Clk,
   input  logic Reset,
   input  logic tick,
   input  logic held,
   input  logic force_idle,
   output logic pulse
);

   localparam int CW = cnt_width(FIRST_DELAY, REPEAT);
   localparam logic [CW-1:0] FD_LAST =
      CW'((FIRST_DELAY > 0) ? FIRST_DELAY - 1 : 0);
   localparam logic [CW-1:0] RP_LAST =
      CW'((REPEAT > 0) ? REPEAT - 1 : 0);
   // State entered on a fresh press
   localparam repeat_state_t PRESS_STATE =
      (DO_REPEAT && (FIRST_DELAY == 0)) ? RS_ARR : RS_DAS;

   repeat_state_t   r_state, w_state_nx;
   logic [CW-1:0]   r_cnt, w_cnt_nx;
   logic            r_pulse, w_pulse_nx;

   // State, counter and pulse registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= RS_IDLE;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_pulse <= w_pulse_nx;
      end
   end

   // Next-state and pulse decision, evaluated only on tick cycles
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_pulse_nx = 1'b0;
      if (tick) begin
         if (force_idle || !held) begin
            w_state_nx = RS_IDLE;
            w_cnt_nx   = '0;
         end else begin
            case (r_state)
               RS_IDLE: begin
                  w_pulse_nx = 1'b1;
                  w_cnt_nx   = '0;
                  w_state_nx = PRESS_STATE;
               end
               RS_DAS: begin
                  // Edge-only channels park here until release
                  if (DO_REPEAT) begin
                     if (r_cnt == FD_LAST) begin
                        w_pulse_nx = 1'b1;
                        w_cnt_nx   = '0;
                        w_state_nx = RS_ARR;
                     end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                     end
                  end
               end
               RS_ARR: begin
                  if (r_cnt == RP_LAST) begin
                     w_pulse_nx = 1'b1;
                     w_cnt_nx   = '0;
                  end else begin
                     w_cnt_nx = r_cnt + CW'(1);
                  end
               end
               default: begin
                  w_state_nx = RS_IDLE;
                  w_cnt_nx   = '0;
               end
            endcase
         end
      end
   end

   assign pulse = r_pulse;

endmodule

// File: rtl/key_repeat_ctrl.sv
// key_repeat_ctrl: converts the NIOS 32-bit keycode word into frame-aligned
// one-cycle move requests for block_logic.
// Optional feature macro: HARD_DROP_EN. When defined, space produces an
// edge-only hard_drop pulse and suppresses soft drop while held; when not
// defined, hard_drop is tied low and space is ignored.
module key_repeat_ctrl
   import key_repeat_ctrl_pkg::*;
#(
   parameter int DAS_FRAMES      = 10,
   parameter int ARR_FRAMES      = 2,
   parameter int DOWN_ARR_FRAMES = 3
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [31:0]         keycode,
   input  logic                VGA_VS,
   output logic [MV_WIDTH-1:0] move_req,
   output logic                hard_drop,
   output logic                frame_tick
);

   logic r_vs_s1, r_vs_s2, r_vs_s3;
   logic r_frame_tick;
   logic w_tick;

   logic w_held_left, w_held_right, w_held_down, w_held_rot_l, w_held_rot_r;
   logic w_lr_conflict;
   logic w_down_force;

   logic w_pulse_left, w_pulse_right, w_pulse_down;
   logic w_pulse_rot_l, w_pulse_rot_r;

   // VGA_VS crosses from the pixel clock domain: two flops to synchronise,
   // a third to detect the rising edge
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_vs_s1 <= 1'b0;
         r_vs_s2 <= 1'b0;
         r_vs_s3 <= 1'b0;
      end else begin
         r_vs_s1 <= VGA_VS;
         r_vs_s2 <= r_vs_s1;
         r_vs_s3 <= r_vs_s2;
      end
   end

   assign w_tick = r_vs_s2 & ~r_vs_s3;

   // Registered tick so frame_tick lines up with the registered pulses
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_frame_tick <= 1'b0;
      else       r_frame_tick <= w_tick;
   end

   assign frame_tick = r_frame_tick;

   // Key decode; only consumed by the channels on tick cycles
   assign w_held_left  = key_held(keycode, KEY_LEFT);
   assign w_held_right = key_held(keycode, KEY_RIGHT);
   assign w_held_down  = key_held(keycode, KEY_DOWN);
   assign w_held_rot_l = key_held(keycode, KEY_ROT_L);
   assign w_held_rot_r = key_held(keycode, KEY_ROT_R);

   // Opposite directions cancel; both channels sit in IDLE until one lifts
   assign w_lr_conflict = w_held_left & w_held_right;

   key_repeat_channel #(
      .FIRST_DELAY (DAS_FRAMES),
      .REPEAT      (ARR_FRAMES),
      .DO_REPEAT   (1'b1)
   ) u_left (
      .Clk        (Clk),
      .Reset      (Reset),
      .tick       (w_tick),
      .held       (w_held_left),
      .force_idle (w_lr_conflict),
      .pulse      (w_pulse_left)
   );

   key_repeat_channel #(
      .FIRST_DELAY (DAS_FRAMES),
      .REPEAT      (ARR_FRAMES),
      .DO_REPEAT   (1'b1)
   ) u_right (
      .Clk        (Clk),
      .Reset      (Reset),
      .tick       (w_tick),
      .held       (w_held_right),
      .force_idle (w_lr_conflict),
      .pulse      (w_pulse_right)
   );

   // Soft drop repeats from the first frame with no DAS stage
   key_repeat_channel #(
      .FIRST_DELAY (0),
      .REPEAT      (DOWN_ARR_FRAMES),
      .DO_REPEAT   (1'b1)
   ) u_down (
      .Clk        (Clk),
      .Reset      (Reset),
      .tick       (w_tick),
      .held       (w_held_down),
      .force_idle (w_down_force),
      .pulse      (w_pulse_down)
   );

   key_repeat_channel #(
      .FIRST_DELAY (1),
      .REPEAT      (1),
      .DO_REPEAT   (1'b0)
   ) u_rot_l (
      .Clk        (Clk),
      .Reset      (Reset),
      .tick       (w_tick),
      .held       (w_held_rot_l),
      .force_idle (1'b0),
      .pulse      (w_pulse_rot_l)
   );

   key_repeat_channel #(
      .FIRST_DELAY (1),
      .REPEAT      (1),
      .DO_REPEAT   (1'b0)
   ) u_rot_r (
      .Clk        (Clk),
      .Reset      (Reset),
      .tick       (w_tick),
      .held       (w_held_rot_r),
      .force_idle (1'b0),
      .pulse      (w_pulse_rot_r)
   );

`ifdef HARD_DROP_EN
   logic w_held_drop;
   logic w_pulse_drop;

   assign w_held_drop  = key_held(keycode, KEY_DROP);
   // Space overrides soft drop so a hard drop never races a down step
   assign w_down_force = w_held_drop;

   key_repeat_channel #(
      .FIRST_DELAY (1),
      .REPEAT      (1),
      .DO_REPEAT   (1'b0)
   ) u_drop (
      .Clk        (Clk),
      .Reset      (Reset),
      .tick       (w_tick),
      .held       (w_held_drop),
      .force_idle (1'b0),
      .pulse      (w_pulse_drop)
   );

   assign hard_drop = w_pulse_drop;
`else
   assign w_down_force = 1'b0;
   assign hard_drop    = 1'b0;
`endif

   // Pack channel pulses into block_logic's can_move bit order
   always_comb begin
      move_req           = '0;
      move_req[MV_LEFT]  = w_pulse_left;
      move_req[MV_RIGHT] = w_pulse_right;
      move_req[MV_DOWN]  = w_pulse_down;
      move_req[MV_ROT_L] = w_pulse_rot_l;
      move_req[MV_ROT_R] = w_pulse_rot_r;
   end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Bench for key_repeat_ctrl: frame-by-frame stimulus, a hold-count reference
// model feeding an expected queue, and a final pass/total report.
module tb_key_repeat_ctrl;

  localparam int DAS  = 10;
  localparam int ARR  = 2;
  localparam int DARR = 3;
  localparam int MAX_LAT = 8;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic [31:0] keycode;
  logic        vga_vs;
  logic [4:0]  move_req;
  logic        hard_drop;
  logic        frame_tick;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  key_repeat_ctrl #(
    .DAS_FRAMES      (DAS),
    .ARR_FRAMES      (ARR),
    .DOWN_ARR_FRAMES (DARR)
  ) dut (
    .Clk        (clk),
    .Reset      (rst),
    .keycode    (keycode),
    .VGA_VS     (vga_vs),
    .move_req   (move_req),
    .hard_drop  (hard_drop),
    .frame_tick (frame_tick)
  );

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];   // {hard_drop, rot_r, rot_l, down, right, left}
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  // Counts consecutive held frames per action and derives pulses from it.
  int h_l = 0, h_r = 0, h_d = 0;
  bit p_rl = 0, p_rr = 0, p_hd = 0;

  function automatic bit has(input logic [31:0] kc, input logic [7:0] code);
    bit hit = 0;
    for (int i = 0; i < 4; i++) if (kc[8*i +: 8] == code) hit = 1;
    return hit;
  endfunction

  task automatic model_reset();
    h_l = 0; h_r = 0; h_d = 0;
    p_rl = 0; p_rr = 0; p_hd = 0;
  endtask

  task automatic model_step(input logic [31:0] kc);
    bit l, r, d, rl, rr, sp;
    logic [5:0] e;
    l  = has(kc, 8'h50);
    r  = has(kc, 8'h4F);
    d  = has(kc, 8'h51);
    rl = has(kc, 8'h1D);
    rr = has(kc, 8'h1B);
`ifdef HARD_DROP_EN
    sp = has(kc, 8'h2C);
`else
    sp = 0;
`endif
    if (l && r) begin
      h_l = 0; h_r = 0;
    end else begin
      h_l = l ? h_l + 1 : 0;
      h_r = r ? h_r + 1 : 0;
    end
    h_d = (d && !sp) ? h_d + 1 : 0;
    e = '0;
    e[0] = (h_l == 1) || (h_l > DAS && ((h_l - 1 - DAS) % ARR) == 0);
    e[1] = (h_r == 1) || (h_r > DAS && ((h_r - 1 - DAS) % ARR) == 0);
    e[2] = (h_d > 0) && (((h_d - 1) % DARR) == 0);
    e[3] = rl && !p_rl;
    e[4] = rr && !p_rr;
    e[5] = sp && !p_hd;
    p_rl = rl; p_rr = rr; p_hd = sp;
    exp_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  // One frame: present keycode, raise VS, expect frame_tick 3 edges later
  // with the predicted pulses, then silence until the next frame.
  task automatic run_frame(input logic [31:0] kc, input bit glitch);
    int lat;
    logic [5:0] e;
    logic [5:0] noise;
    keycode = kc;
    model_step(kc);
    @(negedge clk);
    vga_vs = 1'b1;
    lat = 0;
    noise = '0;
    while (lat < MAX_LAT) begin
      @(negedge clk);
      lat++;
      if (frame_tick) break;
      noise |= {hard_drop, move_req};
    end
    check("tick_latency", lat, 3);
    check("early_quiet", noise, 0);
    e = exp_q.pop_front();
    check("frame_out", {hard_drop, move_req}, e);
    @(negedge clk);
    check("one_cycle", {frame_tick, hard_drop, move_req}, 0);
    vga_vs = 1'b0;
    if (glitch) begin
      keycode = 32'h0;
      repeat (3) @(negedge clk);
      keycode = kc;
    end
    noise = '0;
    repeat (6) begin
      @(negedge clk);
      noise |= {frame_tick, hard_drop, move_req};
    end
    check("between_frames", noise, 0);
  endtask

  task automatic run_frames(input logic [31:0] kc, input int n);
    for (int i = 0; i < n; i++) run_frame(kc, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] codes [8];
    logic [31:0] kc;
    logic [5:0] e;
    codes[0] = 8'h00; codes[1] = 8'h50; codes[2] = 8'h4F; codes[3] = 8'h51;
    codes[4] = 8'h1D; codes[5] = 8'h1B; codes[6] = 8'h2C; codes[7] = 8'h00;

    rst = 1'b1;
    vga_vs = 1'b0;
    keycode = 32'h0000_0050;
    repeat (4) @(negedge clk);
    check("reset_outputs", {frame_tick, hard_drop, move_req}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Left held from reset: pulses on frames 1, 11, 13, 15
    run_frames(32'h0000_0050, 15);
    // Mid-gap keycode glitches must not register as a release
    run_frame(32'h0000_0050, 1'b1);
    run_frame(32'h0000_0050, 1'b1);
    run_frames(32'h0, 1);

    // Left+right conflict, then right alone becomes a new press
    run_frames(32'h0000_4F50, 20);
    run_frames(32'h0000_004F, 3);
    run_frames(32'h0, 1);

    // Soft drop: pulses on frames 1, 4, 7, none after release
    run_frames(32'h0000_0051, 7);
    run_frames(32'h0, 2);

    // Both rotations: edge only, again after release and reapply
    run_frames(32'h1D00_001B, 5);
    run_frames(32'h0, 1);
    run_frames(32'h1D00_001B, 2);
    run_frames(32'h0, 1);

    // Space with down (hard drop behaviour depends on HARD_DROP_EN)
    run_frames(32'h0000_2C51, 4);
    run_frames(32'h0000_0051, 2);
    run_frames(32'h0, 1);

    // Random mixes of relevant codes, duplicates and junk
    for (int i = 0; i < 24; i++) begin
      kc = '0;
      for (int s = 0; s < 4; s++) begin
        if ($urandom_range(0, 5) == 0) kc[8*s +: 8] = 8'($urandom_range(1, 255));
        else kc[8*s +: 8] = codes[$urandom_range(0, 7)];
      end
      run_frames(kc, $urandom_range(1, 4));
    end
    run_frames(32'h0, 1);

    // Asynchronous reset while left is in the repeat phase
    run_frames(32'h0000_0050, 12);
    keycode = 32'h0000_0050;
    model_step(32'h0000_0050);
    e = exp_q.pop_front();
    @(negedge clk);
    vga_vs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_pulse", {frame_tick, hard_drop, move_req}, {1'b1, e});
    rst = 1'b1;
    #1;
    check("async_reset_clears", {frame_tick, hard_drop, move_req}, 0);
    model_reset();
    @(negedge clk);
    vga_vs = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_frames(32'h0000_0050, 3);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_repeat_ctrl.md
Name: key_repeat_ctrl

Overview:
- Upstream stage of the block logic: turns the 32-bit NIOS keycode word (four USB HID key slots) into one-Clk-cycle move-request pulses.
- Request pulses are aligned to frame boundaries (VGA_VS).
- Implements press detection, delayed auto-shift (DAS) and auto-repeat (ARR) per action, plus left/right conflict suppression.
- Output bit order matches the 5-bit can_move vector so block_logic can AND them directly.

Parameters:
- DAS_FRAMES, 10, frames a left/right key must be held after the initial pulse before repeating begins (>=1).
- ARR_FRAMES, 2, frames between repeat pulses for left/right (>=1).
- DOWN_ARR_FRAMES, 3, frames between soft-drop pulses while down is held; no DAS stage for down (>=1).

Ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  asynchronous, active-high reset.
- keycode  in  32  four HID keycodes, slot i = keycode[8i+7:8i]; 0x00 = empty slot.
- VGA_VS  in  1  vertical sync from the VGA controller (VGA_CLK domain); its rising edge marks a frame.
- move_req  out  5  one-cycle request pulses: [0] left, [1] right, [2] down, [3] rotate_left, [4] rotate_right.
- hard_drop  out  1  one-cycle hard-drop pulse (see Optional Feature).
- frame_tick  out  1  one-cycle pulse per detected frame; drives the downstream gravity counter.

Behaviour:
- Reset: all outputs 0, all channels IDLE, all counters 0, sync flops 0. Reset asserted mid-hold returns every channel to IDLE. A key still held after release of reset counts as a new press on the first tick.
- Frame detect: vs_s1 -> vs_s2 -> vs_s3 flop chain. Internal tick = vs_s2 & ~vs_s3. The frame_tick output is the tick registered, so it asserts on the 3rd Clk edge after VGA_VS rises, for exactly one cycle.
- Key decode: on a tick, each action is "held" if any of the 4 slots matches its code.
  - left 0x50, right 0x4F, down 0x51, rotate_left 0x1D (Z), rotate_right 0x1B (X), hard_drop 0x2C (space).
  - Duplicate codes across slots count once.
  - keycode is sampled only on tick cycles; changes between ticks are ignored.
- All state advances only on tick cycles. Outputs are registered and valid in the same cycle as frame_tick; they are 0 on every other cycle.
- Left/right channel FSM: IDLE, DAS, ARR; cnt is $clog2(max(DAS,ARR))+1 bits.
  - IDLE & held: pulse, cnt<=0, go to DAS.
  - DAS & held: if cnt==DAS_FRAMES-1, pulse, cnt<=0, go to ARR; else cnt++.
  - ARR & held: if cnt==ARR_FRAMES-1, pulse, cnt<=0; else cnt++.
  - Any state & not held: go to IDLE, cnt<=0, no pulse.
- Conflict: if left and right are both held, both channels are forced to IDLE and neither pulses. When one is released, the remaining key is treated as a new press on the next tick.
- Down channel: IDLE, REP.
  - IDLE & held: pulse, cnt<=0, go to REP.
  - REP & held: if cnt==DOWN_ARR_FRAMES-1, pulse, cnt<=0; else cnt++.
  - Release: go to IDLE.
- Rotation channels: edge-only, no repeat. Pulse on the tick where held is 1 and prev_held is 0; prev_held is updated each tick. rotate_left and rotate_right may pulse together; block_logic arbitrates.
- The block performs no legality checking; masking with can_move is downstream.

Optional Feature:
- Macro HARD_DROP_EN.
- Defined: hard_drop is an edge-only channel on 0x2C, same rules as rotation. While space is held, move_req[2] is suppressed and the down channel is forced to IDLE.
- Undefined: the hard_drop port still exists and is tied to 0; space is ignored and the down channel is unaffected.

Decomposition:
- Package types gets:
  - KEY_LEFT/KEY_RIGHT/KEY_DOWN/KEY_ROT_L/KEY_ROT_R/KEY_DROP 8-bit constants.
  - MV_LEFT..MV_ROT_R bit-index constants shared with block_logic.
  - enum repeat_state_t {RS_IDLE, RS_DAS, RS_ARR}.
- Sub-module key_repeat_channel (params FIRST_DELAY, REPEAT, DO_REPEAT; ports Clk, Reset, tick, held, force_idle, pulse), instantiated once per action.

Test Plan:
- Reset with keycode=0x00000050 held, release reset, VS edges every 1000 cycles -> move_req[0] pulses on tick 1, 11, 13, 15 (DAS=10, ARR=2), each exactly 1 cycle, 3 Clk edges after VS rise.
- keycode=0x00004F50 (left+right) for 20 frames -> move_req[1:0]=0 throughout. Then keycode=0x0000004F -> move_req[1] on the next tick.
- keycode=0x00000051 for 7 frames -> move_req[2] on ticks 1, 4, 7. Release at frame 8 -> no further pulses.
- keycode=0x1D00001B held 5 frames, then released and reapplied -> rotate_left and rotate_right pulse together only on tick 1 and on the first tick after reapply.
- keycode changes 0x50 -> 0x00 -> 0x50 between two VS edges -> no pulse. Reset asserted in ARR state -> outputs 0 immediately (async); first tick after release pulses.
- HARD_DROP_EN defined, keycode=0x00002C51 -> hard_drop=1 once, move_req[2]=0. Undefined -> hard_drop stays 0, and move_req[2] follows the down-channel schedule.
